mdio_master: RTL and testbench
==============================

// Module: mdio_master
// PURPOSE
//  IEEE 802.3 Clause 22 MDIO management master for the GigE front-end PHYs.
//  Serialises register read/write commands onto MDC/MDIO once strap config completes.
//  Returns read data and a turnaround error flag.
//  One instance per PHY. The top level ties off MDC and floats MIO; each instance replaces that.
//  Top-level tristate: phyN_gm_mio = mdio_oe ? mdio_o : 1'bz.
// PARAMETERS
//  MDC_DIV  20  clk_50 cycles per MDC half-period (min 2); 20 -> 1.25 MHz MDC
// PORTS
//  clk_50        in   1   50 MHz system clock; the only clock
//  reset_n       in   1   asynchronous, active-low reset
//  cmd_valid     in   1   command request
//  cmd_ready     out  1   high only in IDLE; cmd accepted when valid&&ready
//  cmd_write     in   1   1=write (OP 01), 0=read (OP 10)
//  cmd_phy_addr  in   5   PHYAD
//  cmd_reg_addr  in   5   REGAD
//  cmd_wdata     in   16  write data (ignored for reads)
//  rsp_valid     out  1   one-cycle pulse at frame end (reads and writes)
//  rsp_rdata     out  16  read data; held until next rsp_valid; 0 after writes
//  rsp_err       out  1   read TA error (PHY did not drive 0); held with rsp_rdata
//  busy          out  1   high from accept until the rsp_valid cycle inclusive
//  mdc           out  1   management clock to PHY
//  mdio_o        out  1   MDIO drive value
//  mdio_oe       out  1   MDIO output enable
//  mdio_i        in   1   MDIO pin input (externally pulled up)
// BEHAVIOUR
//  Reset values:
//   - mdc=0, mdio_o=1, mdio_oe=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
//   - cmd_ready=1 (state IDLE).
//  Reset mid-frame: outputs return to reset values immediately (async); no rsp_valid. Next frame restarts from preamble.
//  Accept: on accept edge, latch all cmd_* fields; cmd_ready drops the next cycle. cmd_valid while !cmd_ready is ignored.
//  Bit timing:
//   - Bit period = 2*MDC_DIV clocks: low phase (MDC_DIV), then high phase (MDC_DIV).
//   - mdio_o updates at the start of each low phase.
//   - mdio_i is registered on the clock where mdc rises.
//   - First low phase starts the cycle after accept.
//  FSM: IDLE -> PRE(32 bits of 1) -> HDR(14: ST=01, OP, PHYAD[4:0], REGAD[4:0], MSB first)
//       -> TA(2) -> DATA(16, MSB first) -> DONE -> IDLE.
//  Write: oe=1 for all 64 bits; TA=10; DATA=cmd_wdata.
//  Read:
//   - oe=1 through HDR; oe=0 from the start of TA bit 1 to frame end.
//   - Sample TA bit 2: if 1, set rsp_err=1.
//   - 16 DATA samples -> rsp_rdata. Data is still captured on error.
//  DONE:
//   - After the final high phase, mdc=0 and oe=0.
//   - rsp_valid pulses one cycle, exactly 128*MDC_DIV+1 cycles after the accept edge.
//   - cmd_ready=1 next cycle. A new cmd may be accepted immediately (no idle bits).
//  Counters: bit counter 6 bits (0..63); divider counter wide enough for MDC_DIV-1 and wraps to 0.
//  mdc is held 0 in IDLE; never toggles without an active frame.
// CONFIGURATION
//  MDIO_PRE_SUPPRESS_EN
//   - Defined: adds input cmd_no_pre (latched at accept). When 1, PRE is skipped:
//     frame is 32 bits and rsp_valid comes at 64*MDC_DIV+1 cycles. When 0, timing is as above.
//   - Undefined: port absent; every frame carries the 32-bit preamble.
// TESTING
//  1 MDC_DIV=2, write phy=0x01 reg=0x00 data=0x1140 -> 32x'1', then 0101_00001_00000_10_0001000101000000;
//    oe=1 throughout; rsp_valid@257; rsp_rdata=0.
//  2 Read phy=0x03 reg=0x02, PHY model drives TA2=0 and 0x796D -> rsp_rdata=0x796D, rsp_err=0;
//    oe=0 from start of TA bit 1.
//  3 Read with no PHY driving (pull-up) -> rsp_err=1, rsp_rdata=0xFFFF.
//  4 cmd_valid held high, second cmd presented mid-frame -> ignored until DONE;
//    accepted the cycle after rsp_valid; only 2 frames total.
//  5 reset_n low at bit 40 -> mdc=0, oe=0 same cycle; no rsp_valid;
//    next read after release produces a full 64-bit frame.
//  6 MDIO_PRE_SUPPRESS_EN, cmd_no_pre=1, MDC_DIV=2 -> first bits 01 (no preamble); rsp_valid@129.

Source files
------------

// File: rtl/mdio_master.sv
// rtl/mdio_master.sv - Clause 22 MDIO management master (optional preamble suppression: MDIO_PRE_SUPPRESS_EN)
module mdio_master #(
    parameter int MDC_DIV = 20
) (
    input  logic        clk_50,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [4:0]  cmd_phy_addr,
    input  logic [4:0]  cmd_reg_addr,
    input  logic [15:0] cmd_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
    input  logic        cmd_no_pre,
`endif
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i
);

    localparam int DW = $clog2(MDC_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_HDR,
        S_TA,
        S_DATA,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;
    logic [DW-1:0]  div_cnt;
    logic           phase_hi;
    logic [5:0]     bit_cnt;
    logic [63:0]    frame;
    logic           is_read;
    logic [15:0]    rdata_sh;
    logic           err_sh;

    logic           no_pre;
    logic           accept;
    logic           active;
    logic           half_end;
    logic           rise;
    logic           bit_end;
    logic [5:0]     nxt_bit;
    logic [5:0]     start_bit;
    logic [63:0]    frame_new;

`ifdef MDIO_PRE_SUPPRESS_EN
    assign no_pre = cmd_no_pre;
`else
    assign no_pre = 1'b0;
`endif

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign accept    = (state == S_IDLE) && cmd_valid;
    assign active    = (state != S_IDLE) && (state != S_DONE);
    assign half_end  = active && (div_cnt == DW'(MDC_DIV - 1));
    assign rise      = half_end && !phase_hi;
    assign bit_end   = half_end && phase_hi;
    assign nxt_bit   = bit_cnt + 6'd1;
    assign start_bit = no_pre ? 6'd32 : 6'd0;

    // Frame image, bit 63 goes out first; read TA/DATA slots are never driven.
    assign frame_new = {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10),
                        cmd_phy_addr, cmd_reg_addr,
                        (cmd_write ? 2'b10 : 2'b11),
                        (cmd_write ? cmd_wdata : 16'hFFFF)};

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (cmd_valid) state_nxt = no_pre ? S_HDR : S_PRE;
            S_PRE:  if (bit_end && bit_cnt == 6'd31) state_nxt = S_HDR;
            S_HDR:  if (bit_end && bit_cnt == 6'd45) state_nxt = S_TA;
            S_TA:   if (bit_end && bit_cnt == 6'd47) state_nxt = S_DATA;
            S_DATA: if (bit_end && bit_cnt == 6'd63) state_nxt = S_DONE;
            S_DONE: if (div_cnt == DW'(1)) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt   <= '0;
            phase_hi  <= 1'b0;
            bit_cnt   <= '0;
            frame     <= '0;
            is_read   <= 1'b0;
            rdata_sh  <= '0;
            err_sh    <= 1'b0;
            mdc       <= 1'b0;
            mdio_o    <= 1'b1;
            mdio_oe   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            if (accept) begin
                frame    <= frame_new;
                is_read  <= !cmd_write;
                bit_cnt  <= start_bit;
                div_cnt  <= '0;
                phase_hi <= 1'b0;
                mdc      <= 1'b0;
                mdio_o   <= frame_new[~start_bit];
                mdio_oe  <= 1'b1;
            end else if (active) begin
                div_cnt <= half_end ? '0 : div_cnt + 1'b1;
                if (rise) begin
                    mdc      <= 1'b1;
                    phase_hi <= 1'b1;
                    // A PHY that answers pulls TA bit 2 low; a floating bus reads 1.
                    if (state == S_TA && bit_cnt == 6'd47) err_sh <= mdio_i;
                    if (state == S_DATA) rdata_sh <= {rdata_sh[14:0], mdio_i};
                end else if (bit_end) begin
                    mdc      <= 1'b0;
                    phase_hi <= 1'b0;
                    if (bit_cnt == 6'd63) begin
                        mdio_o  <= 1'b1;
                        mdio_oe <= 1'b0;
                    end else begin
                        bit_cnt <= nxt_bit;
                        mdio_o  <= frame[~nxt_bit];
                        mdio_oe <= !(is_read && nxt_bit >= 6'd46);
                    end
                end
            end else if (state == S_DONE) begin
                // Two-cycle tail: bus released first, response reported second.
                if (div_cnt == '0) begin
                    div_cnt   <= DW'(1);
                    rsp_valid <= 1'b1;
                    rsp_rdata <= is_read ? rdata_sh : 16'h0000;
                    rsp_err   <= is_read && err_sh;
                end else begin
                    div_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mdio_master.sv
// tb/tb_mdio_master.sv - randomized self-checking bench for mdio_master against a frame-offset model
module tb_mdio_master;

    localparam int D = 2;

    logic        clk_50 = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [4:0]  cmd_phy_addr = '0;
    logic [4:0]  cmd_reg_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic        cmd_no_pre = 1'b0;
    logic        cmd_ready;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        mdc;
    logic        mdio_o;
    logic        mdio_oe;
    logic        mdio_i;

    logic        phy_val = 1'b1;
    logic        phy_en = 1'b0;
    logic        phy_ta2 = 1'b0;
    logic [15:0] phy_data = '0;

    int          n_tests = 0;
    int          n_fail = 0;

    assign mdio_i = mdio_oe ? mdio_o : phy_val;

    always #5 clk_50 = ~clk_50;

    mdio_master #(.MDC_DIV(D)) dut (
        .clk_50       (clk_50),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_phy_addr (cmd_phy_addr),
        .cmd_reg_addr (cmd_reg_addr),
        .cmd_wdata    (cmd_wdata),
`ifdef MDIO_PRE_SUPPRESS_EN
        .cmd_no_pre   (cmd_no_pre),
`endif
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .mdc          (mdc),
        .mdio_o       (mdio_o),
        .mdio_oe      (mdio_oe),
        .mdio_i       (mdio_i)
    );

    // Model: a frame is an offset k counted in clocks from the accept edge.
    int          m_act = 0;
    int          m_k = 0;
    int          m_total = 0;
    int          m_start = 0;
    logic        m_read = 1'b0;
    logic [63:0] m_frame = '0;
    logic        m_phy_en = 1'b0;
    logic        m_phy_ta2 = 1'b0;
    logic [15:0] m_phy_data = '0;
    logic [15:0] exp_rdata = '0;
    logic        exp_err = 1'b0;

    always @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            m_act = 0;
            m_k = 0;
            exp_rdata = '0;
            exp_err = 1'b0;
        end else if (m_act != 0) begin
            m_k = m_k + 1;
            if (m_k == m_total + 1) begin
                exp_rdata = m_read ? (m_phy_en ? m_phy_data : 16'hFFFF) : 16'h0000;
                exp_err   = m_read ? (m_phy_en ? m_phy_ta2 : 1'b1) : 1'b0;
            end
            if (m_k == m_total + 2) m_act = 0;
        end else if (cmd_valid) begin
            m_read     = !cmd_write;
            m_frame    = {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10),
                          cmd_phy_addr, cmd_reg_addr, 2'b10, cmd_wdata};
            m_start    = cmd_no_pre ? 32 : 0;
            m_total    = (64 - m_start) * 2 * D;
            m_phy_en   = phy_en;
            m_phy_ta2  = phy_ta2;
            m_phy_data = phy_data;
            m_act = 1;
            m_k = 0;
        end
    end

    logic [63:0] cap = '0;
    logic [63:0] oecap = '0;
    logic        prev_mdc = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        int   b;
        logic e_mdc;
        logic e_oe;
        logic e_rv;
        b = 0;
        e_mdc = 1'b0;
        e_oe = 1'b0;
        if (m_act != 0 && m_k < m_total) begin
            b = m_start + m_k / (2 * D);
            e_mdc = (m_k % (2 * D)) >= D;
            e_oe = !m_read || (b < 46);
        end
        e_rv = (m_act != 0) && (m_k == m_total + 1);
        check("mdc", 64'(mdc), 64'(e_mdc));
        check("mdio_oe", 64'(mdio_oe), 64'(e_oe));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        check("busy", 64'(busy), 64'(m_act != 0));
        check("cmd_ready", 64'(cmd_ready), 64'(m_act == 0));
        check("rsp_rdata", 64'(rsp_rdata), 64'(exp_rdata));
        check("rsp_err", 64'(rsp_err), 64'(exp_err));
        if (e_oe) check("mdio_o", 64'(mdio_o), 64'(m_frame[63 - b]));
        phy_val = 1'b1;
        if (m_act != 0 && m_k < m_total && m_read && m_phy_en) begin
            if (b == 47) phy_val = m_phy_ta2;
            else if (b >= 48) phy_val = m_phy_data[63 - b];
        end
        if (!prev_mdc && mdc) begin
            cap = {cap[62:0], mdio_o};
            oecap = {oecap[62:0], mdio_oe};
        end
        prev_mdc = mdc;
    endtask

    task automatic tick();
        @(negedge clk_50);
        compare_cycle();
        #1;
    endtask

    task automatic present(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                           input logic [15:0] wd, input logic np);
        int g;
        cmd_write = w;
        cmd_phy_addr = pa;
        cmd_reg_addr = ra;
        cmd_wdata = wd;
        cmd_no_pre = np;
        cmd_valid = 1'b1;
        g = 0;
        while (!cmd_ready && g < 1000) begin
            tick();
            g++;
        end
        check("accept_wait", 64'(g < 1000), 64'(1));
        tick();
    endtask

    task automatic send(input logic w, input logic [4:0] pa, input logic [4:0] ra,
                        input logic [15:0] wd, input logic np, output int lat);
        present(w, pa, ra, wd, np);
        cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin
            tick();
            lat++;
        end
        check("rsp_wait", 64'(lat < 2000), 64'(1));
    endtask

    initial begin
        int          lat;
        int          r1;
        int          extra;
        int          g;
        logic        w;
        logic        np;
        logic [13:0] hdr;

        repeat (3) tick();
        check("reset_mdc", 64'(mdc), 64'(0));
        check("reset_mdio_o", 64'(mdio_o), 64'(1));
        check("reset_oe", 64'(mdio_oe), 64'(0));
        check("reset_ready", 64'(cmd_ready), 64'(1));
        check("reset_rdata", 64'(rsp_rdata), 64'(0));
        reset_n = 1'b1;
        repeat (2) tick();

        // Write frame with hand-derived bit image
        send(1'b1, 5'h01, 5'h00, 16'h1140, 1'b0, lat);
        check("t1_latency", 64'(lat), 64'(257));
        check("t1_bits", cap, 64'hFFFF_FFFF_5082_1140);
        check("t1_oe", oecap, 64'hFFFF_FFFF_FFFF_FFFF);
        check("t1_rdata", 64'(rsp_rdata), 64'(0));
        tick();

        // Read answered by PHY
        phy_en = 1'b1; phy_ta2 = 1'b0; phy_data = 16'h796D;
        send(1'b0, 5'h03, 5'h02, 16'h0000, 1'b0, lat);
        check("t2_rdata", 64'(rsp_rdata), 64'h796D);
        check("t2_err", 64'(rsp_err), 64'(0));
        check("t2_oe", oecap, 64'hFFFF_FFFF_FFFC_0000);
        tick();

        // Read with nothing on the bus
        phy_en = 1'b0;
        send(1'b0, 5'h03, 5'h02, 16'h0000, 1'b0, lat);
        check("t3_rdata", 64'(rsp_rdata), 64'hFFFF);
        check("t3_err", 64'(rsp_err), 64'(1));
        tick();

        // Second command held during a frame
        phy_en = 1'b1; phy_ta2 = 1'b0; phy_data = 16'hA5C3;
        present(1'b1, 5'h05, 5'h06, 16'h1234, 1'b0);
        cmd_write = 1'b0; cmd_phy_addr = 5'h07; cmd_reg_addr = 5'h08;
        lat = 0;
        while (!rsp_valid && lat < 2000) begin tick(); lat++; end
        check("t4_first_lat", 64'(lat), 64'(257));
        r1 = 0;
        g = 0;
        while (!cmd_ready && g < 100) begin tick(); r1++; g++; end
        tick(); r1++;
        cmd_valid = 1'b0;
        while (!rsp_valid && r1 < 2000) begin tick(); r1++; end
        check("t4_spacing", 64'(r1), 64'(259));
        check("t4_rdata", 64'(rsp_rdata), 64'hA5C3);
        extra = 0;
        repeat (300) begin tick(); if (rsp_valid) extra++; end
        check("t4_no_third", 64'(extra), 64'(0));

        // Reset in the middle of bit 40
        present(1'b0, 5'h1F, 5'h05, 16'h0000, 1'b0);
        cmd_valid = 1'b0;
        repeat (160) tick();
        reset_n = 1'b0;
        #1;
        check("t5_mdc", 64'(mdc), 64'(0));
        check("t5_oe", 64'(mdio_oe), 64'(0));
        check("t5_busy", 64'(busy), 64'(0));
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
        phy_data = 16'h0F0F;
        send(1'b0, 5'h1F, 5'h05, 16'h0000, 1'b0, lat);
        hdr = {2'b01, 2'b10, 5'h1F, 5'h05};
        check("t5_latency", 64'(lat), 64'(257));
        check("t5_pre", 64'(cap[63:32]), 64'hFFFF_FFFF);
        check("t5_hdr", 64'(cap[31:18]), 64'(hdr));
        check("t5_rdata", 64'(rsp_rdata), 64'h0F0F);
        tick();

`ifdef MDIO_PRE_SUPPRESS_EN
        send(1'b1, 5'h01, 5'h00, 16'h1140, 1'b1, lat);
        check("t6_latency", 64'(lat), 64'(129));
        check("t6_bits", 64'(cap[31:0]), 64'h5082_1140);
        tick();
`endif

        for (int i = 0; i < 30; i++) begin
            w = 1'($urandom_range(0, 1));
            np = 1'b0;
`ifdef MDIO_PRE_SUPPRESS_EN
            np = 1'($urandom_range(0, 1));
`endif
            phy_en = 1'($urandom_range(0, 3) != 0);
            phy_ta2 = 1'($urandom_range(0, 3) == 0);
            phy_data = 16'($urandom);
            repeat ($urandom_range(0, 3)) tick();
            send(w, 5'($urandom), 5'($urandom), 16'($urandom), np, lat);
            check("rand_latency", 64'(lat), 64'(np ? 64 * D + 1 : 128 * D + 1));
        end
        repeat (5) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
